// File: rtl/dbus_demux_if.sv
// Core-side and target-side data-bus signals of the data-memory demux.
// slave is the demux view; master is the view of the core and targets around it.
interface dbus_demux_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              m_req_valid;
    logic              m_req_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_we;
    logic [3:0]        m_be;
    logic              m_rsp_valid;
    logic [DATA_W-1:0] m_rdata;
    logic              m_err;

    logic              s0_req_valid;
    logic              s0_req_ready;
    logic [ADDR_W-1:0] s0_addr;
    logic [DATA_W-1:0] s0_wdata;
    logic              s0_we;
    logic [3:0]        s0_be;
    logic              s0_rsp_valid;
    logic [DATA_W-1:0] s0_rdata;

    logic              s1_req_valid;
    logic              s1_req_ready;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_wdata;
    logic              s1_we;
    logic [3:0]        s1_be;
    logic              s1_rsp_valid;
    logic [DATA_W-1:0] s1_rdata;

    modport slave (
        input  m_req_valid, m_addr, m_wdata, m_we, m_be,
        output m_req_ready, m_rsp_valid, m_rdata, m_err,
        output s0_req_valid, s0_addr, s0_wdata, s0_we, s0_be,
        input  s0_req_ready, s0_rsp_valid, s0_rdata,
        output s1_req_valid, s1_addr, s1_wdata, s1_we, s1_be,
        input  s1_req_ready, s1_rsp_valid, s1_rdata
    );

    modport master (
        output m_req_valid, m_addr, m_wdata, m_we, m_be,
        input  m_req_ready, m_rsp_valid, m_rdata, m_err,
        input  s0_req_valid, s0_addr, s0_wdata, s0_we, s0_be,
        output s0_req_ready, s0_rsp_valid, s0_rdata,
        input  s1_req_valid, s1_addr, s1_wdata, s1_we, s1_be,
        output s1_req_ready, s1_rsp_valid, s1_rdata
    );
endinterface

// File: rtl/dbus_demux.sv
// Data-bus demux: steers one outstanding core request to data RAM (target 0)
// or the MMIO window (target 1), with misalignment and timeout error responses.
module dbus_demux #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 32'hFFFF0000,
    parameter logic [ADDR_W-1:0] MMIO_MASK = 32'hFFFF0000,
    parameter int unsigned       TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    dbus_demux_if.slave     bus
);
    localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic              sel_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              accept;
    logic              misalign;
    logic              sel_ready, sel_rsp;
    logic [DATA_W-1:0] sel_rdata;

    assign misalign = ((bus.m_be == 4'b1111) && (bus.m_addr[1:0] != 2'b00)) ||
                      (((bus.m_be == 4'b0011) || (bus.m_be == 4'b1100)) && bus.m_addr[0]);

    assign sel_ready = sel_q ? bus.s1_req_ready : bus.s0_req_ready;
    assign sel_rsp   = sel_q ? bus.s1_rsp_valid : bus.s0_rsp_valid;
    assign sel_rdata = sel_q ? bus.s1_rdata     : bus.s0_rdata;

    // Handshake outputs decode straight from state so reset clears them asynchronously
    assign bus.m_req_ready  = (state_q == IDLE);
    assign bus.m_rsp_valid  = (state_q == RESP);
    assign bus.m_rdata      = rdata_q;
    assign bus.m_err        = err_q;
    assign bus.s0_req_valid = (state_q == REQ) && !sel_q;
    assign bus.s1_req_valid = (state_q == REQ) &&  sel_q;
    assign bus.s0_addr      = addr_q;
    assign bus.s0_wdata     = wdata_q;
    assign bus.s0_we        = we_q;
    assign bus.s0_be        = be_q;
    assign bus.s1_addr      = addr_q;
    assign bus.s1_wdata     = wdata_q;
    assign bus.s1_we        = we_q;
    assign bus.s1_be        = be_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.m_req_valid) begin
                    accept = 1'b1;
                    cnt_d  = '0;
                    if (misalign) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == TMO_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                end else if (sel_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the final cycle beats the timeout
                if (sel_rsp) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = sel_rdata;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            sel_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                addr_q  <= bus.m_addr;
                wdata_q <= bus.m_wdata;
                we_q    <= bus.m_we;
                be_q    <= bus.m_be;
                sel_q   <= ((bus.m_addr & MMIO_MASK) == MMIO_BASE);
            end
        end
    end
endmodule
